// File: rtl/qpu_exu_moitf_pkg.sv
// ---------------------------------------------------------------------------
// qpu_exu_moitf_pkg
//  Shared definitions for the measure outstanding-instruction tracking FIFO.
//  - QPU_QUBIT_NUM   : width of qubit lists and measurement results
//  - QPU_MOITF_DEPTH : default number of outstanding measure entries
//  - moitf_op_e      : per-cycle pointer activity (idle / push / pop / both)
// ---------------------------------------------------------------------------
package qpu_exu_moitf_pkg;

   localparam int unsigned QPU_QUBIT_NUM   = 16;
   localparam int unsigned QPU_MOITF_DEPTH = 4;

   typedef enum logic [1:0] {
      MOITF_IDLE     = 2'b00,
      MOITF_POP      = 2'b01,
      MOITF_PUSH     = 2'b10,
      MOITF_PUSH_POP = 2'b11
   } moitf_op_e;

   function automatic moitf_op_e moitf_op(input logic push, input logic pop);
      moitf_op_e op;
      unique case ({push, pop})
         2'b10:   op = MOITF_PUSH;
         2'b01:   op = MOITF_POP;
         2'b11:   op = MOITF_PUSH_POP;
         default: op = MOITF_IDLE;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/qpu_exu_moitf_flag.sv
// ---------------------------------------------------------------------------
// qpu_exu_moitf_flag
//  OR-reduction of the qubit lists of all valid MOITF entries.
//  Ports:
//   qlist  in   DEPTH x QN  stored qubit list per entry
//   vld    in   DEPTH       entry valid bits
//   flag   out  QN          union of the qubit lists of valid entries
// ---------------------------------------------------------------------------
module qpu_exu_moitf_flag
   import qpu_exu_moitf_pkg::*;
#(
   parameter int unsigned DEPTH = QPU_MOITF_DEPTH,
   parameter int unsigned QN    = QPU_QUBIT_NUM
) (
   input  logic [DEPTH-1:0][QN-1:0] qlist,
   input  logic [DEPTH-1:0]         vld,
   output logic [QN-1:0]            flag
);

   always_comb begin
      flag = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (vld[i]) begin
            flag = flag | qlist[i];
         end
      end
   end

endmodule

// File: rtl/qpu_exu_moitf.sv
// ---------------------------------------------------------------------------
// qpu_exu_moitf
//  Measure outstanding-instruction tracking FIFO for the QPU execute unit.
//  Records the qubit list of every dispatched measure in program order,
//  exports the union of outstanding lists so dispatch can stall overlapping
//  FMR/measure instructions, and pairs in-order measurement results with the
//  head entry for QMR writeback.
//  Ports:
//   clk, rst              clock, synchronous active-high reset
//   disp_moitf_ena        in   enqueue a dispatched measure
//   disp_moitf_ready      out  FIFO not full
//   disp_oitf_qubitlist   in   qubit list of the dispatching instruction
//   disp_oitf_qfren       in   dispatching instruction uses qubit flags
//   oitfqf_match_dispql   out  dispatch list overlaps an outstanding entry
//   moitf_qubit_flag      out  OR of all valid entry qubit lists
//   moitf_empty           out  no outstanding measure
//   mres_valid/ready/data      measurement result return (in order)
//   moitf_ret_valid/ready      retire handshake towards QMR writeback
//   moitf_ret_qubitlist   out  head entry qubit list (write mask)
//   moitf_ret_data        out  measured values, passed through from mres_data
// ---------------------------------------------------------------------------
module qpu_exu_moitf
   import qpu_exu_moitf_pkg::*;
#(
   parameter int unsigned MOITF_DEPTH = QPU_MOITF_DEPTH,
   parameter int unsigned PTR_W       = $clog2(MOITF_DEPTH),
   parameter int unsigned QN          = QPU_QUBIT_NUM
) (
   input  logic          clk,
   input  logic          rst,

   input  logic          disp_moitf_ena,
   output logic          disp_moitf_ready,
   input  logic [QN-1:0] disp_oitf_qubitlist,
   input  logic          disp_oitf_qfren,
   output logic          oitfqf_match_dispql,
   output logic [QN-1:0] moitf_qubit_flag,
   output logic          moitf_empty,

   input  logic          mres_valid,
   output logic          mres_ready,
   input  logic [QN-1:0] mres_data,

   output logic          moitf_ret_valid,
   input  logic          moitf_ret_ready,
   output logic [QN-1:0] moitf_ret_qubitlist,
   output logic [QN-1:0] moitf_ret_data
);

   localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

   // Pointers carry one wrap bit above the index so full and empty differ.
   logic [PTR_W:0]                   wptr_q, wptr_d;
   logic [PTR_W:0]                   rptr_q, rptr_d;
   logic [MOITF_DEPTH-1:0]           vld_q, vld_d;
   logic [MOITF_DEPTH-1:0][QN-1:0]   qlist_q, qlist_d;

   logic [PTR_W-1:0] widx, ridx;
   logic             empty, full;
   logic             push, pop;
   moitf_op_e        op;
   logic [QN-1:0]    flag;

   assign widx  = wptr_q[PTR_W-1:0];
   assign ridx  = rptr_q[PTR_W-1:0];
   assign empty = (wptr_q == rptr_q);
   assign full  = (widx == ridx) && (wptr_q[PTR_W] != rptr_q[PTR_W]);

   // ----------------------------------------------------------------------
   // Handshakes
   // ----------------------------------------------------------------------
   // Ready depends only on registered occupancy: a pop this cycle never
   // frees a slot for a same-cycle enqueue.
   assign disp_moitf_ready = ~full;
   assign push             = disp_moitf_ena & ~full;

   // Results are never taken in a reset cycle, the entry is being dropped.
   assign mres_ready      = moitf_ret_ready & ~empty & ~rst;
   assign moitf_ret_valid = mres_valid & ~empty;
   assign pop             = mres_valid & mres_ready;

   assign moitf_ret_qubitlist = qlist_q[ridx];
   assign moitf_ret_data      = mres_data;

   assign op = moitf_op(push, pop);

   // ----------------------------------------------------------------------
   // Next state
   // ----------------------------------------------------------------------
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      vld_d   = vld_q;
      qlist_d = qlist_q;
      unique case (op)
         MOITF_PUSH: begin
            wptr_d        = wptr_q + PTR_ONE;
            vld_d[widx]   = 1'b1;
            qlist_d[widx] = disp_oitf_qubitlist;
         end
         MOITF_POP: begin
            rptr_d      = rptr_q + PTR_ONE;
            vld_d[ridx] = 1'b0;
         end
         MOITF_PUSH_POP: begin
            // Neither empty nor full here, so widx != ridx.
            wptr_d        = wptr_q + PTR_ONE;
            rptr_d        = rptr_q + PTR_ONE;
            vld_d[widx]   = 1'b1;
            vld_d[ridx]   = 1'b0;
            qlist_d[widx] = disp_oitf_qubitlist;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         vld_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         vld_q  <= vld_d;
      end
   end

   // Entry payload needs no reset; the valid bits qualify it.
   always_ff @(posedge clk) begin
      qlist_q <= qlist_d;
   end

   // ----------------------------------------------------------------------
   // Outstanding qubit flag and dispatch match
   // ----------------------------------------------------------------------
   // Built from registers only, so an entry enqueued this cycle is excluded
   // and an entry popping this cycle still counts (one extra stall cycle).
   qpu_exu_moitf_flag #(
      .DEPTH (MOITF_DEPTH),
      .QN    (QN)
   ) u_flag (
      .qlist (qlist_q),
      .vld   (vld_q),
      .flag  (flag)
   );

   assign moitf_qubit_flag    = flag;
   assign moitf_empty         = empty;
   assign oitfqf_match_dispql = disp_oitf_qfren & (|(disp_oitf_qubitlist & flag));

   // ----------------------------------------------------------------------
   // Protocol checks
   // ----------------------------------------------------------------------
   a_no_enq_when_full : assert property (
      @(posedge clk) disable iff (rst) !(disp_moitf_ena && full));

   a_no_result_when_empty : assert property (
      @(posedge clk) disable iff (rst) !(mres_valid && empty));

endmodule

// File: tb/tb_qpu_exu_moitf.sv
module tb_qpu_exu_moitf;

   localparam int unsigned QN = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          disp_moitf_ena;
   logic          disp_moitf_ready;
   logic [QN-1:0] disp_oitf_qubitlist;
   logic          disp_oitf_qfren;
   logic          oitfqf_match_dispql;
   logic [QN-1:0] moitf_qubit_flag;
   logic          moitf_empty;
   logic          mres_valid;
   logic          mres_ready;
   logic [QN-1:0] mres_data;
   logic          moitf_ret_valid;
   logic          moitf_ret_ready;
   logic [QN-1:0] moitf_ret_qubitlist;
   logic [QN-1:0] moitf_ret_data;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   qpu_exu_moitf #(
      .MOITF_DEPTH (4),
      .QN          (QN)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .disp_moitf_ena      (disp_moitf_ena),
      .disp_moitf_ready    (disp_moitf_ready),
      .disp_oitf_qubitlist (disp_oitf_qubitlist),
      .disp_oitf_qfren     (disp_oitf_qfren),
      .oitfqf_match_dispql (oitfqf_match_dispql),
      .moitf_qubit_flag    (moitf_qubit_flag),
      .moitf_empty         (moitf_empty),
      .mres_valid          (mres_valid),
      .mres_ready          (mres_ready),
      .mres_data           (mres_data),
      .moitf_ret_valid     (moitf_ret_valid),
      .moitf_ret_ready     (moitf_ret_ready),
      .moitf_ret_qubitlist (moitf_ret_qubitlist),
      .moitf_ret_data      (moitf_ret_data)
   );

   typedef struct {
      logic [QN-1:0] qlist;
      logic          qfren;
      logic          exp_match;
   } match_vec_t;

   match_vec_t    vecs [8];
   logic [QN-1:0] fill [4];
   logic [QN-1:0] model [$];
   logic [QN-1:0] exp_flag;
   logic [QN-1:0] popped;
   int            k;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [QN-1:0] wv(input int n);
      logic [QN-1:0] one;
      one = 16'h0001;
      return one << (n % 12);
   endfunction

   function automatic logic [QN-1:0] model_or();
      logic [QN-1:0] r;
      r = '0;
      for (int i = 0; i < model.size(); i++) r = r | model[i];
      return r;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; disp_moitf_ena = 1'b0; disp_oitf_qubitlist = '0; disp_oitf_qfren = 1'b0;
      mres_valid = 1'b0; mres_data = '0; moitf_ret_ready = 1'b1;

      vecs[0] = '{16'h0002, 1'b1, 1'b1};
      vecs[1] = '{16'h0002, 1'b0, 1'b0};
      vecs[2] = '{16'h0100, 1'b1, 1'b0};
      vecs[3] = '{16'h0003, 1'b1, 1'b1};
      vecs[4] = '{16'h0001, 1'b1, 1'b1};
      vecs[5] = '{16'h00FC, 1'b1, 1'b0};
      vecs[6] = '{16'hFFFF, 1'b1, 1'b1};
      vecs[7] = '{16'h0000, 1'b1, 1'b0};
      fill[0] = 16'h0003; fill[1] = 16'h000C; fill[2] = 16'h0030; fill[3] = 16'h00C0;

      tick(); tick();
      rst = 1'b0;

      // Reset state held over idle cycles
      for (int i = 0; i < 10; i++) begin
         settle();
         chk("idle_ready", disp_moitf_ready, 1);
         chk("idle_empty", moitf_empty, 1);
         chk("idle_flag", moitf_qubit_flag, 0);
         chk("idle_ret_valid", moitf_ret_valid, 0);
         chk("idle_mres_ready", mres_ready, 0);
         chk("idle_match", oitfqf_match_dispql, 0);
         tick();
      end

      // Fill to capacity
      exp_flag = '0;
      for (int i = 0; i < 4; i++) begin
         disp_moitf_ena = 1'b1; disp_oitf_qubitlist = fill[i];
         settle();
         chk("fill_ready", disp_moitf_ready, 1);
         chk("fill_flag_pre", moitf_qubit_flag, exp_flag);
         tick();
         exp_flag = exp_flag | fill[i];
         disp_moitf_ena = 1'b0;
         settle();
         chk("fill_flag_post", moitf_qubit_flag, exp_flag);
      end
      chk("full_ready", disp_moitf_ready, 0);
      chk("full_flag", moitf_qubit_flag, 16'h00FF);
      chk("full_empty", moitf_empty, 0);
      chk("full_ret_valid", moitf_ret_valid, 0);
      chk("full_head", moitf_ret_qubitlist, 16'h0003);

      // Drain in order; no pass-through while popping from full
      mres_valid = 1'b1; moitf_ret_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         mres_data = 16'(i + 1);
         settle();
         chk("drain_ret_valid", moitf_ret_valid, 1);
         chk("drain_mres_ready", mres_ready, 1);
         chk("drain_qlist", moitf_ret_qubitlist, fill[i]);
         chk("drain_data", moitf_ret_data, 32'(i + 1));
         if (i == 0) chk("full_pop_ready", disp_moitf_ready, 0);
         tick();
      end
      mres_valid = 1'b0;
      settle();
      chk("drain_empty", moitf_empty, 1);
      chk("drain_flag", moitf_qubit_flag, 0);
      chk("drain_ready", disp_moitf_ready, 1);

      // Dispatch match table against a single outstanding 0x003
      disp_moitf_ena = 1'b1; disp_oitf_qubitlist = 16'h0003;
      tick();
      disp_moitf_ena = 1'b0;
      for (int i = 0; i < 8; i++) begin
         disp_oitf_qubitlist = vecs[i].qlist;
         disp_oitf_qfren     = vecs[i].qfren;
         settle();
         chk("match_vec", oitfqf_match_dispql, vecs[i].exp_match);
      end
      // The popping entry still counts this cycle
      disp_oitf_qubitlist = 16'h0002; disp_oitf_qfren = 1'b1;
      mres_valid = 1'b1; mres_data = 16'h0001;
      settle();
      chk("match_during_pop", oitfqf_match_dispql, 1);
      tick();
      mres_valid = 1'b0;
      settle();
      chk("match_after_pop", oitfqf_match_dispql, 0);
      chk("match_empty", moitf_empty, 1);
      disp_oitf_qfren = 1'b0;

      // In-order retire; enqueue into empty visible only next cycle
      disp_moitf_ena = 1'b1; disp_oitf_qubitlist = 16'h0003;
      settle();
      chk("enq_empty_flag", moitf_qubit_flag, 0);
      chk("enq_empty_empty", moitf_empty, 1);
      tick();
      disp_oitf_qubitlist = 16'h000C;
      settle();
      chk("enq2_flag", moitf_qubit_flag, 16'h0003);
      tick();
      disp_moitf_ena = 1'b0;
      mres_valid = 1'b1; mres_data = 16'h0001;
      settle();
      chk("ret1_valid", moitf_ret_valid, 1);
      chk("ret1_qlist", moitf_ret_qubitlist, 16'h0003);
      chk("ret1_data", moitf_ret_data, 16'h0001);
      chk("ret1_flag", moitf_qubit_flag, 16'h000F);
      tick();
      mres_data = 16'h0008;
      settle();
      chk("ret2_valid", moitf_ret_valid, 1);
      chk("ret2_qlist", moitf_ret_qubitlist, 16'h000C);
      chk("ret2_data", moitf_ret_data, 16'h0008);
      tick();
      mres_valid = 1'b0;
      settle();
      chk("ret_empty", moitf_empty, 1);
      chk("ret_flag", moitf_qubit_flag, 0);

      // Back-pressure
      disp_moitf_ena = 1'b1; disp_oitf_qubitlist = 16'h0030;
      tick();
      disp_moitf_ena = 1'b0;
      mres_valid = 1'b1; mres_data = 16'h0010; moitf_ret_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("bp_mres_ready", mres_ready, 0);
         chk("bp_ret_valid", moitf_ret_valid, 1);
         chk("bp_head", moitf_ret_qubitlist, 16'h0030);
         tick();
      end
      chk("bp_not_empty", moitf_empty, 0);
      moitf_ret_ready = 1'b1;
      settle();
      chk("bp_release", mres_ready, 1);
      tick();
      mres_valid = 1'b0;
      settle();
      chk("bp_one_pop", moitf_empty, 1);

      // Wrap with simultaneous enqueue and pop at occupancy 3
      k = 0;
      for (int i = 0; i < 3; i++) begin
         disp_moitf_ena = 1'b1; disp_oitf_qubitlist = wv(k);
         tick();
         model.push_back(wv(k));
         k++;
      end
      for (int i = 0; i < 20; i++) begin
         disp_moitf_ena = 1'b1; disp_oitf_qubitlist = wv(k);
         mres_valid = 1'b1; mres_data = 16'(i); moitf_ret_ready = 1'b1;
         settle();
         chk("wrap_ready", disp_moitf_ready, 1);
         chk("wrap_ret_valid", moitf_ret_valid, 1);
         chk("wrap_head", moitf_ret_qubitlist, model[0]);
         chk("wrap_flag", moitf_qubit_flag, model_or());
         tick();
         popped = model.pop_front();
         model.push_back(wv(k));
         k++;
      end
      disp_moitf_ena = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("wrap_drain_valid", moitf_ret_valid, 1);
         chk("wrap_drain_head", moitf_ret_qubitlist, model[0]);
         tick();
         popped = model.pop_front();
      end
      mres_valid = 1'b0;
      settle();
      chk("wrap_occupancy", moitf_empty, 1);

      // Reset mid-stream
      for (int i = 0; i < 3; i++) begin
         disp_moitf_ena = 1'b1; disp_oitf_qubitlist = wv(i + 3);
         tick();
      end
      disp_moitf_ena = 1'b0;
      mres_valid = 1'b1; mres_data = 16'h00AA; rst = 1'b1;
      settle();
      chk("rst_mres_ready", mres_ready, 0);
      tick();
      rst = 1'b0; mres_valid = 1'b0;
      settle();
      chk("rst_empty", moitf_empty, 1);
      chk("rst_flag", moitf_qubit_flag, 0);
      chk("rst_ready", disp_moitf_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
